reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; the register count is 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 insAddress  input  ADDR_W  write register address, driven by the register-destination mux output.
REQ-006 wData  input  DATA_W  write data.
REQ-007 regWrite  input  1  write enable.
REQ-008 rAddr1  input  ADDR_W  read port 1 address.
REQ-009 rAddr2  input  ADDR_W  read port 2 address.
REQ-010 rData1  output  DATA_W  read port 1 data.
REQ-011 rData2  output  DATA_W  read port 2 data.
REQ-012 ready  output  1  high when the bank is initialised and accepts writes.

Function
REQ-013 The block SHALL hold 32 registers of DATA_W bits, plus a 2-state FSM (CLEAR, READY) and a 5-bit clear counter clrCnt.
REQ-014 In CLEAR with rst low, each rising edge SHALL write 0 to register clrCnt and then increment clrCnt.
REQ-015 In CLEAR, the edge that writes register 31 SHALL move the FSM to READY and wrap clrCnt to 0.
REQ-016 READY SHALL be held until the next rst; no other transition exists.
REQ-017 ready SHALL be 1 only in READY; ready is registered, with no combinational path from any input.
REQ-018 In READY, on a rising edge with regWrite=1 and insAddress!=0, wData SHALL be stored into register insAddress.
REQ-019 Writes to address 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-020 With regWrite=1 while ready=0, the write SHALL be discarded silently, with no later replay.
REQ-021 Reads SHALL be combinational: rDataN = register[rAddrN], zero-latency.
REQ-022 Write-first bypass: in READY, when regWrite=1 and rAddrN==insAddress!=0, rDataN SHALL equal wData in that same cycle.
REQ-023 While ready=0, rData1 and rData2 SHALL be forced to 0 regardless of address.
REQ-024 Both read ports SHALL operate independently and may address the same register simultaneously.
REQ-025 rAddr1, rAddr2 and insAddress SHALL be full-width compares; there SHALL be no aliasing and all 32 addresses SHALL be valid.
REQ-026 Register contents SHALL be unchanged on any edge that does not meet REQ-014 or REQ-018.

Reset
REQ-027 A rising edge with rst=1 SHALL set state=CLEAR, clrCnt=0 and ready=0; that edge writes no register.
REQ-028 rst SHALL take priority over regWrite and over clear progress on the same edge.
REQ-029 rst asserted mid-clear SHALL restart the clear from clrCnt=0; no partial credit.
REQ-030 rst asserted in READY SHALL re-enter CLEAR and zero all 32 registers again.
REQ-031 From the first edge with rst low, ready SHALL rise after exactly 32 rising edges.
REQ-032 rData1 and rData2 SHALL read 0 from the reset edge until ready=1.

Verification
REQ-033 Hold rst 2 cycles, then release -> ready=0 for 32 edges, ready=1 after the 32nd edge; rData1 reads 0 for rAddr1 = 0..31.
REQ-034 In READY, set insAddress=7, wData=32'hDEADBEEF, regWrite=1, rAddr1=7 -> rData1=DEADBEEF in the same cycle (bypass) and still DEADBEEF after regWrite=0.
REQ-035 Write 32'hFFFFFFFF to address 0, read rAddr1=rAddr2=0 -> both ports read 0, same cycle and next cycle.
REQ-036 During CLEAR, write 32'h12345678 to address 3 -> write dropped; after ready=1, rAddr2=3 reads 0.
REQ-037 Assert rst 10 edges into CLEAR (after r5=0x55 written in a prior READY period) -> ready rises 32 edges after the new release; r5 reads 0.
REQ-038 Write r3=3 and r7=7 on consecutive cycles, then set rAddr1=3, rAddr2=7 -> rData1=3, rData2=7; swapping the addresses swaps the outputs.

Source files
------------

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file -- 2**ADDR_W x DATA_W general-purpose register bank with two
// combinational read ports, one synchronous write port and a self-clearing
// start-up sequence.
//
// After reset the bank walks through every register, writing zero, one
// register per clock. Only when the walk completes does `ready` rise and
// external writes become effective. Until then both read ports return zero.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   insAddress  in   write address (register-destination mux output)
//   wData       in   write data
//   regWrite    in   write enable
//   rAddr1      in   read port 1 address
//   rAddr2      in   read port 2 address
//   rData1      out  read port 1 data (combinational, write-first bypass)
//   rData2      out  read port 2 data (combinational, write-first bypass)
//   ready       out  registered; high once the bank is cleared
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] insAddress,
    input  logic [DATA_W-1:0] wData,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rAddr1,
    input  logic [ADDR_W-1:0] rAddr2,
    output logic [DATA_W-1:0] rData1,
    output logic [DATA_W-1:0] rData2,
    output logic              ready
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic clearing;
    logic wr_en;

    // ---------------------------------------------------------------------
    // Control FSM: CLEAR walks clr_cnt through every address, READY is
    // terminal until the next reset.
    // ---------------------------------------------------------------------
    assign clearing = (state_q == ST_CLEAR);
    assign wr_en    = (state_q == ST_READY) && regWrite && (insAddress != ADDR_ZERO);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clearing) begin
            // Counter wraps naturally to 0 on the edge that clears the last register.
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_LAST) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ready is decoded straight from the state flop, so it has no path
    // from any input.
    assign ready = (state_q == ST_READY);

    // ---------------------------------------------------------------------
    // Register storage. Each register has its own enable: the clear walk
    // zeroes it when the counter points at it, otherwise an external write
    // loads it. The reset edge itself writes nothing. Register 0 is only
    // ever written by the clear walk, so it holds zero permanently.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] MY_ADDR = gi[ADDR_W-1:0];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (clearing) begin
                        if (clr_cnt_q == MY_ADDR) begin
                            regs_q[gi] <= '0;
                        end
                    end else if (wr_en && (insAddress == MY_ADDR)) begin
                        regs_q[gi] <= wData;
                    end
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Read ports: zero while not ready, zero for address 0, write-first
    // bypass when the same non-zero address is being written this cycle.
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = rAddr1;
    assign rd_addr[1] = rAddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = '0;
                if (ready && (rd_addr[gi] != ADDR_ZERO)) begin
                    if (wr_en && (rd_addr[gi] == insAddress)) begin
                        rd_data[gi] = wData;
                    end else begin
                        rd_data[gi] = regs_q[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign rData1 = rd_data[0];
    assign rData2 = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file -- directed self-checking bench for reg_file.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at least
// 1 ns after the inputs settle, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] insAddress;
    logic [DATA_W-1:0] wData;
    logic              regWrite;
    logic [ADDR_W-1:0] rAddr1;
    logic [ADDR_W-1:0] rAddr2;
    logic [DATA_W-1:0] rData1;
    logic [DATA_W-1:0] rData2;
    logic              ready;

    int pass_cnt;
    int total_cnt;

    reg_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .insAddress(insAddress),
        .wData     (wData),
        .regWrite  (regWrite),
        .rAddr1    (rAddr1),
        .rAddr2    (rAddr2),
        .rData1    (rData1),
        .rData2    (rData2),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("check %-24s got %08h exp %08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-24s got %08h exp %08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        insAddress = a;
        wData      = d;
        regWrite   = 1'b1;
    endtask

    // Release reset and verify ready rises on exactly the 32nd edge.
    task automatic wait_clear(input string tag);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31 || i == 32 || i == 1) begin
                check($sformatf("%s_rdy_e%0d", tag, i), {31'd0, ready},
                      (i == 32) ? 32'd1 : 32'd0);
            end else if (ready !== 1'b0) begin
                check($sformatf("%s_rdy_e%0d", tag, i), {31'd0, ready}, 32'd0);
            end
        end
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst        = 1'b1;
        insAddress = '0;
        wData      = '0;
        regWrite   = 1'b0;
        rAddr1     = 5'd4;
        rAddr2     = 5'd9;

        // Reset held for two edges.
        tick();
        tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata1", rData1, 32'd0);
        check("rst_rdata2", rData2, 32'd0);

        // Release; keep trying to write address 3 during the whole clear.
        rst = 1'b0;
        drive_write(5'd3, 32'h12345678);
        rAddr1 = 5'd3;
        #1;
        check("clear_rdata1_forced0", rData1, 32'd0);
        wait_clear("clr1");
        regWrite = 1'b0;

        // Every register reads zero after the clear; dropped write to r3.
        rAddr2 = 5'd3;
        #1;
        check("clear_drop_r3", rData2, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rAddr1 = a[ADDR_W-1:0];
            #1;
            if (rData1 !== 32'd0 || a == 0 || a == 31) begin
                check($sformatf("zero_r%0d", a), rData1, 32'd0);
            end
        end

        // Bypass on write of r7.
        drive_write(5'd7, 32'hDEADBEEF);
        rAddr1 = 5'd7;
        #1;
        check("bypass_r7", rData1, 32'hDEADBEEF);
        tick();
        regWrite = 1'b0;
        #1;
        check("stored_r7", rData1, 32'hDEADBEEF);

        // Writes to r0 are discarded.
        drive_write(5'd0, 32'hFFFFFFFF);
        rAddr1 = 5'd0;
        rAddr2 = 5'd0;
        #1;
        check("r0_same_p1", rData1, 32'd0);
        check("r0_same_p2", rData2, 32'd0);
        tick();
        regWrite = 1'b0;
        #1;
        check("r0_next_p1", rData1, 32'd0);
        check("r0_next_p2", rData2, 32'd0);

        // Back-to-back writes, then independent and swapped reads.
        drive_write(5'd3, 32'd3);
        tick();
        drive_write(5'd7, 32'd7);
        tick();
        regWrite = 1'b0;
        rAddr1   = 5'd3;
        rAddr2   = 5'd7;
        #1;
        check("p1_r3", rData1, 32'd3);
        check("p2_r7", rData2, 32'd7);
        rAddr1 = 5'd7;
        rAddr2 = 5'd3;
        #1;
        check("swap_p1_r7", rData1, 32'd7);
        check("swap_p2_r3", rData2, 32'd3);
        rAddr2 = 5'd7;
        #1;
        check("same_p2_r7", rData2, 32'd7);

        // Neighbour addresses untouched (no aliasing).
        rAddr1 = 5'd23;
        rAddr2 = 5'd6;
        #1;
        check("alias_r23", rData1, 32'd0);
        check("alias_r6", rData2, 32'd0);

        // r5 = 0x55 then reset mid-clear after 10 edges.
        drive_write(5'd5, 32'h55);
        tick();
        regWrite = 1'b0;
        rAddr1   = 5'd5;
        #1;
        check("r5_written", rData1, 32'h55);

        // Reset edge with a pending write: reset wins.
        rst = 1'b1;
        drive_write(5'd9, 32'hA5A5A5A5);
        tick();
        check("rst2_ready", {31'd0, ready}, 32'd0);
        check("rst2_rdata1", rData1, 32'd0);
        rst      = 1'b0;
        regWrite = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midclr_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("clr2");

        rAddr1 = 5'd5;
        rAddr2 = 5'd7;
        #1;
        check("reclr_r5", rData1, 32'd0);
        check("reclr_r7", rData2, 32'd0);
        rAddr1 = 5'd9;
        rAddr2 = 5'd3;
        #1;
        check("reclr_r9", rData1, 32'd0);
        check("reclr_r3", rData2, 32'd0);

        // Write after re-clear works again.
        drive_write(5'd31, 32'hCAFEF00D);
        tick();
        regWrite = 1'b0;
        rAddr1   = 5'd31;
        #1;
        check("post_r31", rData1, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
